addr_seq: RTL

Parametrised bit-to-word address sequencer. It owns its bit/word counter and converts a stream of bit-advance ticks into a word address: one address per 2^BIT_W bits. It adds a programmable base address and length, one-shot or looping mode, a start/busy/done handshake and an abort input. It sits between the serial bit engine (which drives adv) and the word memory (which consumes addr).

---
 rtl/addr_seq_pkg.sv | 19 +
 rtl/addr_seq_ctr.sv | 51 +++++
 rtl/addr_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/addr_seq_pkg.sv
// addr_seq_pkg
//   Shared types and helpers for the bit-to-word address sequencer.
//   state_t   : sequencer FSM state encoding
//   calc_len  : words per pass from the programmed num_words (0 -> 2^addr_w)
package addr_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A programmed length of zero means "the whole address space".
   function automatic logic [31:0] calc_len(input logic [31:0] num_words,
                                            input int          addr_w);
      return (num_words == 32'd0) ? (32'd1 << addr_w) : num_words;
   endfunction

endpackage

// File: rtl/addr_seq_ctr.sv
// addr_seq_ctr
//   Bit/word position counter for one sequencer pass.
//   sysclk        : system clock, rising edge
//   reset         : synchronous active-high reset
//   inc           : advance one bit
//   clr           : return to bit 0 of word 0 (start of pass)
//   len           : words in the current pass (1 .. 2^ADDR_W)
//   bit_idx       : bit position within the current word
//   word_cnt      : word offset from the pass base
//   word_boundary : current bit is the last bit of a word
//   last_word     : current word is the last word of the pass
module addr_seq_ctr
   import addr_seq_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int BIT_W  = 3,
   parameter int BI_W   = (BIT_W > 0) ? BIT_W : 1
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              inc,
   input  logic              clr,
   input  logic [ADDR_W:0]   len,
   output logic [BI_W-1:0]   bit_idx,
   output logic [ADDR_W-1:0] word_cnt,
   output logic              word_boundary,
   output logic              last_word
);

   // With BIT_W=0 this is 0 and bit_idx never leaves 0, so every bit is a boundary.
   localparam logic [BI_W-1:0] BIT_MAX = BI_W'((1 << BIT_W) - 1);

   assign word_boundary = (bit_idx == BIT_MAX);
   assign last_word     = ({1'b0, word_cnt} == (len - (ADDR_W+1)'(1)));

   always_ff @(posedge sysclk) begin
      if (reset || clr) begin
         bit_idx  <= '0;
         word_cnt <= '0;
      end else if (inc) begin
         if (word_boundary) begin
            bit_idx  <= '0;
            // Wrapping on the last word serves both looping and the one-shot count wrap.
            word_cnt <= last_word ? '0 : word_cnt + ADDR_W'(1);
         end else begin
            bit_idx <= bit_idx + BI_W'(1);
         end
      end
   end

endmodule

// File: rtl/addr_seq.sv
// addr_seq
//   Converts bit-advance ticks into word addresses: one address per 2^BIT_W
//   bits, starting at a programmable base, for a programmable number of words,
//   one-shot or looping.
//   sysclk     : system clock, rising edge
//   reset      : synchronous active-high reset
//   start      : begin a pass (IDLE only); latches mode_loop/base_addr/num_words
//   mode_loop  : 1 = restart at base after the last word
//   base_addr  : first word address
//   num_words  : words per pass, 0 = 2^ADDR_W
//   adv        : bit-advance tick (RUN only)
//   stop       : abort the pass (RUN only, wins over adv)
//   addr       : current word address
//   bit_idx    : bit position within the word
//   count      : bits elapsed in the pass, {word_cnt, bit_idx}
//   word_start : pulse in the first cycle a new addr is valid
//   busy       : high in RUN
//   done       : pulse when a one-shot pass completes
//
// state | meaning
// IDLE  | waiting for start; outputs hold their last values
// RUN   | pass in progress, counting adv ticks
// DONE  | one-cycle completion pulse, then back to IDLE
module addr_seq
   import addr_seq_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int BIT_W  = 3,
   parameter int CNT_W  = ADDR_W + BIT_W
) (
   input  logic                                 sysclk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 mode_loop,
   input  logic [ADDR_W-1:0]                    base_addr,
   input  logic [ADDR_W-1:0]                    num_words,
   input  logic                                 adv,
   input  logic                                 stop,
   output logic [ADDR_W-1:0]                    addr,
   output logic [((BIT_W > 0) ? BIT_W : 1)-1:0] bit_idx,
   output logic [CNT_W-1:0]                     count,
   output logic                                 word_start,
   output logic                                 busy,
   output logic                                 done
);

   localparam int BI_W = (BIT_W > 0) ? BIT_W : 1;

   state_t              state;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W:0]     len_q;
   logic                loop_q;
   logic [ADDR_W-1:0]   word_cnt;
   logic                word_boundary;
   logic                last_word;
   logic                ctr_inc;
   logic                ctr_clr;

   assign ctr_inc = (state == RUN) && adv && !stop;
   assign ctr_clr = (state == IDLE) && start;

   addr_seq_ctr #(
      .ADDR_W (ADDR_W),
      .BIT_W  (BIT_W),
      .BI_W   (BI_W)
   ) u_ctr (
      .sysclk        (sysclk),
      .reset         (reset),
      .inc           (ctr_inc),
      .clr           (ctr_clr),
      .len           (len_q),
      .bit_idx       (bit_idx),
      .word_cnt      (word_cnt),
      .word_boundary (word_boundary),
      .last_word     (last_word)
   );

   generate
      if (BIT_W > 0) begin : g_cnt_bits
         assign count = {word_cnt, bit_idx};
      end else begin : g_cnt_words
         assign count = word_cnt;
      end
   endgenerate

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= '0;
         word_start <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         base_q     <= '0;
         len_q      <= '0;
         loop_q     <= 1'b0;
      end else begin
         word_start <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  base_q     <= base_addr;
                  len_q      <= (ADDR_W+1)'(calc_len(32'(num_words), ADDR_W));
                  loop_q     <= mode_loop;
                  addr       <= base_addr;
                  word_start <= 1'b1;
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (adv && word_boundary) begin
                  if (!last_word) begin
                     // Natural ADDR_W-bit wrap lets a pass cross the top of the address space.
                     addr       <= base_q + word_cnt + ADDR_W'(1);
                     word_start <= 1'b1;
                  end else if (loop_q) begin
                     addr       <= base_q;
                     word_start <= 1'b1;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
